// File: rtl/gauss_sample_arbiter.sv
// gauss_sample_arbiter: waits out the generator warm-up after reset, buffers
// Gaussian samples in a small FIFO and hands them out one per cycle to the
// path engines under round-robin arbitration. Samples arriving while the
// FIFO is full are dropped and counted (saturating).
//
// Handshake: a requester holds req[i] high while it wants samples. A sample
// is delivered in the cycle gnt[i] is high (out_valid = |gnt); there is no
// back-pressure on the delivery side, the grant itself is the transfer.
module gauss_sample_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int WARMUP     = 4
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic [31:0]                   g_randnum_in,
    input  logic                          run,
    input  logic                          flush,
    input  logic [NUM_REQ-1:0]            req,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [31:0]                   out_data,
    output logic                          out_valid,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   drop_cnt,
    output logic                          state_dbg
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    typedef enum logic {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state;
    logic [WW-1:0]       warm_cnt;
    logic [31:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       grant_idx;
    logic [PW-1:0]       cand_idx;
    logic                grant_found;
    logic                capture;
    logic                full;
    logic                pop;
    logic                push;
    logic                drop;

    assign state_dbg = state;

    // Round-robin search: first set req bit starting just after the last grant.
    always_comb begin
        grant_idx   = '0;
        cand_idx    = '0;
        grant_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_idx = PW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!grant_found && req[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    assign capture = (state == ST_RUN) && run && !flush;
    assign full    = (fifo_level == LW'(FIFO_DEPTH));
    assign pop     = !flush && (fifo_level != '0) && grant_found;
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    // Warm-up FSM: count WARMUP edges, then enter RUN and raise ready.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= ST_WARM;
            warm_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                ST_WARM: begin
                    if (warm_cnt == WW'(WARMUP - 1)) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // Sample storage; contents are meaningless outside the level window, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= g_randnum_in;
        end
    end

    // FIFO pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - 1'b1;
            end
        end
    end

    // Registered grant and data; out_data holds its last value when idle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            gnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            rr_ptr    <= PW'(NUM_REQ - 1);
        end else begin
            out_valid <= pop;
            if (pop) begin
                gnt      <= NUM_REQ'(1) << grant_idx;
                out_data <= mem[rd_ptr];
                rr_ptr   <= grant_idx;
            end else begin
                gnt <= '0;
            end
        end
    end

    // Saturating count of samples lost to a full FIFO.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_gauss_sample_arbiter.sv
// Bench for gauss_sample_arbiter: directed scenarios plus random traffic,
// all checked against a queue-based model of the buffer and arbitration rules.
module tb_gauss_sample_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int WARMUP     = 4;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;
    localparam int W          = NUM_REQ + 32;

    logic                 clk;
    logic                 nreset;
    logic [31:0]          din;
    logic                 run;
    logic                 flush;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   gnt;
    logic [31:0]          out_data;
    logic                 out_valid;
    logic                 ready;
    logic [LW-1:0]        fifo_level;
    logic [15:0]          drop_cnt;
    logic                 state_dbg;

    gauss_sample_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .FIFO_DEPTH (FIFO_DEPTH),
        .WARMUP     (WARMUP)
    ) dut (
        .clk          (clk),
        .nreset       (nreset),
        .g_randnum_in (din),
        .run          (run),
        .flush        (flush),
        .req          (req),
        .gnt          (gnt),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .ready        (ready),
        .fifo_level   (fifo_level),
        .drop_cnt     (drop_cnt),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard / model state ----------------
    logic [W-1:0]  exp_q[$];
    logic [31:0]   m_fifo[$];
    int            m_ptr;
    int            m_edges;
    logic [15:0]   m_drop;
    logic [31:0]   m_last;
    int            n_checks;
    int            n_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_fifo.delete();
        m_ptr   = NUM_REQ - 1;
        m_edges = 0;
        m_drop  = '0;
        m_last  = '0;
    endtask

    // One clock: evaluate the rules on pre-edge inputs, then commit after the edge.
    task automatic cycle();
        bit                 pop;
        bit                 push;
        bit                 full;
        int                 gi;
        logic [31:0]        gd;
        logic [NUM_REQ-1:0] gbits;
        pop  = !flush && (m_fifo.size() > 0) && (req != '0);
        gi   = -1;
        if (pop) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int j;
                j = (m_ptr + k) % NUM_REQ;
                if (gi < 0 && req[j]) gi = j;
            end
        end
        gd    = pop ? m_fifo[0] : 32'h0;
        push  = (m_edges >= WARMUP) && run && !flush;
        full  = (m_fifo.size() == FIFO_DEPTH);
        gbits = '0;
        @(posedge clk);
        if (flush) begin
            m_fifo.delete();
        end else begin
            if (pop) begin
                void'(m_fifo.pop_front());
                gbits[gi] = 1'b1;
                exp_q.push_back({gbits, gd});
                m_ptr  = gi;
                m_last = gd;
            end
            if (push) begin
                if (!full || pop) m_fifo.push_back(din);
                else if (m_drop != 16'hFFFF) m_drop++;
            end
        end
        m_edges++;
        #1;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        model_reset();
        req   = NUM_REQ'($urandom_range(0, 15));
        run   = 1'($urandom_range(0, 1));
        flush = 1'($urandom_range(0, 1));
        din   = $urandom;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({gnt, out_data, out_valid, ready, fifo_level, drop_cnt}), 64'h0);
        run    = 1'b0;
        req    = '0;
        flush  = 1'b0;
        nreset = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        bit           had;
        if (nreset) begin
            had = (exp_q.size() != 0);
            check("out_valid", 64'(out_valid), 64'(had));
            if (had) begin
                e = exp_q.pop_front();
                check("gnt_data", 64'({gnt, out_data}), 64'(e));
            end else begin
                check("gnt_idle", 64'(gnt), 64'h0);
            end
            check("out_data_hold", 64'(out_data), 64'(m_last));
            check("fifo_level", 64'(fifo_level), 64'(m_fifo.size()));
            check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            check("ready", 64'(ready), 64'(m_edges >= WARMUP));
        end
    end

    // ---------------- stimulus ----------------
    logic [NUM_REQ-1:0] rr1 [5];
    logic [NUM_REQ-1:0] rr2 [3];
    int                 grants;

    initial begin
        n_checks = 0;
        n_err    = 0;
        nreset   = 1'b0;
        run      = 1'b0;
        flush    = 1'b0;
        req      = '0;
        din      = '0;
        rr1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr2 = '{4'b0010, 4'b1000, 4'b0010};

        // Reset and warm-up timing
        do_reset();
        repeat (WARMUP - 1) cycle();
        check("ready_before_warm", 64'(ready), 64'h0);
        cycle();
        check("ready_after_warm", 64'(ready), 64'h1);

        // Ordering with 2-cycle latency
        run = 1'b1;
        req = 4'b0001;
        for (int i = 1; i <= 24; i++) begin
            din = i;
            cycle();
            if (i == 2) check("first_sample_latency", 64'({gnt, out_data}), 64'({4'b0001, 32'd1}));
        end
        run = 1'b0;
        req = '0;
        repeat (3) cycle();

        // Round robin from a pre-filled FIFO
        do_reset();
        repeat (WARMUP) cycle();
        run = 1'b1;
        repeat (FIFO_DEPTH) begin
            din = $urandom;
            cycle();
        end
        run = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("rr_all", 64'(gnt), 64'(rr1[k]));
        end
        req = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("rr_1010", 64'(gnt), 64'(rr2[k]));
        end
        req = '0;
        cycle();

        // Full / drop
        do_reset();
        repeat (WARMUP) cycle();
        run = 1'b1;
        repeat (20) begin
            din = $urandom;
            cycle();
        end
        check("full_level", 64'(fifo_level), 64'd8);
        check("full_drops", 64'(drop_cnt), 64'd12);
        req = 4'b0001;
        repeat (10) begin
            din = $urandom;
            cycle();
        end
        check("full_pop_level", 64'(fifo_level), 64'd8);
        check("full_pop_drops", 64'(drop_cnt), 64'd12);

        // Flush and run=0 draining
        run   = 1'b0;
        req   = '0;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_empty", 64'(fifo_level), 64'd0);
        run = 1'b1;
        repeat (6) begin
            din = $urandom;
            cycle();
        end
        check("pre_flush_level", 64'(fifo_level), 64'd6);
        flush = 1'b1;
        req   = 4'b0001;
        cycle();
        flush = 1'b0;
        check("flush_level", 64'(fifo_level), 64'd0);
        check("flush_gnt", 64'(gnt), 64'd0);
        req = '0;
        repeat (5) begin
            din = $urandom;
            cycle();
        end
        run    = 1'b0;
        req    = 4'b0001;
        grants = 0;
        repeat (8) begin
            cycle();
            if (out_valid) grants++;
        end
        check("drain_grants", 64'(grants), 64'd5);
        check("drain_idle_gnt", 64'(gnt), 64'd0);

        // Random traffic
        repeat (400) begin
            din   = $urandom;
            run   = ($urandom_range(0, 3) != 0);
            req   = NUM_REQ'($urandom_range(0, 15));
            flush = ($urandom_range(0, 40) == 0);
            cycle();
        end
        flush = 1'b0;

        // Asynchronous reset while granting with the FIFO half full
        run   = 1'b0;
        req   = '0;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        run   = 1'b1;
        repeat (4) begin
            din = $urandom;
            cycle();
        end
        check("half_level", 64'(fifo_level), 64'd4);
        req = 4'b0001;
        din = $urandom;
        cycle();
        check("granting_before_reset", 64'(gnt), 64'b0001);
        nreset = 1'b0;
        #2;
        check("async_reset_outputs", 64'({gnt, out_data, out_valid, ready, fifo_level, drop_cnt}), 64'h0);
        do_reset();
        repeat (WARMUP - 1) cycle();
        check("rewarm_ready_low", 64'(ready), 64'h0);
        cycle();
        check("rewarm_ready_high", 64'(ready), 64'h1);
        run = 1'b1;
        req = 4'b0001;
        repeat (6) begin
            din = $urandom;
            cycle();
        end
        run = 1'b0;
        repeat (4) cycle();
        req = '0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/gauss_sample_arbiter.md
# gauss_sample_arbiter

Scheduler that sits between the free-running Box-Muller Gaussian generator and the Black-Scholes Monte-Carlo path engines. It waits out the generator/multiplier pipeline warm-up after reset, buffers generated 32-bit two's-complement samples in a small FIFO, and hands them out one per cycle to several requesters under round-robin arbitration. Samples that arrive while the FIFO is full are discarded and counted.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- FIFO_DEPTH, 8: sample buffer depth, power of two, at least 2.
- WARMUP, 4: cycles after reset release before generator output is trusted, at least 1.
- clk  in  1  single clock, all logic rising-edge.
- nreset  in  1  asynchronous active-low reset.
- g_randnum_in  in  32  Gaussian sample from the generator; a new value every cycle.
- run  in  1  enables capture of generator samples into the FIFO.
- flush  in  1  synchronous FIFO clear; takes priority over push and pop.
- req  in  NUM_REQ  level requests, one bit per path engine.
- gnt  out  NUM_REQ  registered one-hot grant, at most one bit set.
- out_data  out  32  registered sample, valid in the cycle gnt is set.
- out_valid  out  1  equals OR of gnt.
- ready  out  1  high once warm-up has completed.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- drop_cnt  out  16  saturating count of samples discarded because the FIFO was full.

## Operation
- Reset values: gnt=0, out_data=0, out_valid=0, ready=0, fifo_level=0, drop_cnt=0, round-robin pointer=NUM_REQ-1, state=WARM, warm counter=0.
- State WARM: the warm counter increments every cycle; no pushes occur. When the counter reaches WARMUP-1, the state moves to RUN and ready goes high on the next edge.
- State RUN, push rule: if run=1, the block samples g_randnum_in each cycle.
  - If fifo_level<FIFO_DEPTH, or a pop occurs in the same cycle, the sample is written.
  - Otherwise the sample is dropped and drop_cnt increments, saturating at 16'hFFFF.
- State RUN, run=0: no pushes and no drops are counted. Grants continue from buffered samples.
- Pop/grant rule: each cycle in which fifo_level>0 (registered value) and req≠0, one requester is granted.
  - The search starts at pointer+1 modulo NUM_REQ and takes the first set req bit.
  - gnt is set to that bit, out_data takes the FIFO head, the head is popped, and the pointer takes the granted index.
  - In all other cycles gnt=0 and out_data holds its last value.
- Requesters hold req high for as long as they want samples. A requester that drops req in a cycle is not eligible in that cycle's decision.
- FIFO order is strict first-in first-out. Every captured sample is delivered exactly once, unmodified.
- Push and pop in the same cycle: fifo_level is unchanged. At FIFO_DEPTH this means the push is accepted, not dropped.
- flush=1: fifo_level goes to 0, read and write pointers are cleared, and that cycle's push and pop are suppressed (gnt=0 next cycle). drop_cnt, pointer, and state are unchanged.
- Asynchronous nreset mid-operation: all state returns to reset values immediately, buffered samples are lost, and warm-up restarts.

## Timing
- A sample present on g_randnum_in before edge E0 is written at E0. The earliest it can appear on out_data/gnt is after edge E1, i.e. 2 cycles input-to-output latency.
- With a steady push stream and continuous requests, throughput is 1 sample per cycle.
- The first push occurs at the edge WARMUP+1 cycles after nreset deasserts (WARMUP warm edges, then the first RUN edge).
- fifo_level and drop_cnt update at the same edge as the push/pop that changes them.

## Test plan
- Reset: hold nreset=0 with random req/run/g_randnum_in. All outputs must be 0. After release, ready must rise exactly after WARMUP+... WARM edges: with WARMUP=4, ready=1 after the 4th edge.
- Ordering: run=1, inputs 1,2,3,… per cycle, req=4'b0001 continuously. out_data sequence must be the captured values in order, with no duplicates or gaps, and 2-cycle latency.
- Round robin: FIFO pre-filled, req=4'b1111. gnt must be 0001, 0010, 0100, 1000, 0001. Then with req=4'b1010 starting after grant 0001, gnt must be 0010, 1000, 0010.
- Full/drop: req=0, run=1 for 20 cycles after ready. Result must be fifo_level=8 and drop_cnt=12. Then req=4'b0001 with run=1: fifo_level must stay 8 and drop_cnt must stay 12.
- Run/flush: run=0 with 5 buffered samples and req=0001 gives exactly 5 grants, then gnt=0. flush with fifo_level=6 gives fifo_level=0 next cycle and gnt=0.
- Mid-operation reset: assert nreset=0 while granting with the FIFO half full. All outputs must go to 0 asynchronously (before the next edge), and after release the warm-up must repeat.
